ex_mul_div: RTL and testbench

//   Iterative multi-cycle multiply/divide unit beside the EX-stage ALU. Executes MIPS

---
 rtl/ex_mul_div.sv | 255 +++++++++++++++++++++++++
 tb/tb_ex_mul_div.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_div.sv
// ex_mul_div: iterative multiply/divide unit that sits beside the EX-stage ALU.
// Runs MULT/MULTU/DIV/DIVU as one radix-2 step per cycle on operand magnitudes,
// applies sign correction at the end, and presents the result on the HI/LO write port.
// While the unit is computing, it requests a pipeline stall.
module ex_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic             hilo_write_en,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Two's-complement negation of one operand-width value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] val);
        neg_w = (~val) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a double-width product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] val);
        neg_2w = (~val) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_r;
    state_t               state_next_s;

    // Per-operation context, latched when an op is accepted
    logic [1:0]           op_r;
    logic                 sign_1_r;
    logic                 sign_2_r;
    logic [WIDTH-1:0]     mag_2_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     cnt_r;

    // Sign-corrected result waiting in FINISH, and the committed HI/LO
    logic [WIDTH-1:0]     res_hi_r;
    logic [WIDTH-1:0]     res_lo_r;
    logic                 dz_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    // Input decode
    logic                 accept_s;
    logic                 div_by_zero_s;
    logic                 in_sign_1_s;
    logic                 in_sign_2_s;
    logic [WIDTH-1:0]     in_mag_1_s;
    logic [WIDTH-1:0]     in_mag_2_s;

    // Iteration step
    logic                 last_step_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_trial_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   acc_step_s;

    // Final sign correction
    logic [WIDTH-1:0]     fin_hi_s;
    logic [WIDTH-1:0]     fin_lo_s;

    // Decode the incoming request: signs, magnitudes, acceptance and divide-by-zero
    always_comb begin
        accept_s      = (state_r == ST_IDLE) && start && !cancel;
        div_by_zero_s = op[1] && (operand_2 == {WIDTH{1'b0}});
        in_sign_1_s   = !op[0] && operand_1[WIDTH-1];
        in_sign_2_s   = !op[0] && operand_2[WIDTH-1];
        if (in_sign_1_s) begin
            in_mag_1_s = neg_w(operand_1);
        end else begin
            in_mag_1_s = operand_1;
        end
        if (in_sign_2_s) begin
            in_mag_2_s = neg_w(operand_2);
        end else begin
            in_mag_2_s = operand_2;
        end
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        last_step_s = (cnt_r == CNT_LAST);
        // Multiply: acc = {partial high, remaining multiplier bits}
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mag_2_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
        // The remainder is always below the divisor, so the trial fits in WIDTH+1 bits
        // and the MSB of the difference is a clean borrow flag.
        div_trial_s = acc_r[2*WIDTH-1:WIDTH-1];
        div_diff_s  = div_trial_s - {1'b0, mag_2_r};
        if (op_r[1]) begin
            if (!div_diff_s[WIDTH]) begin
                acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign-correct the result produced by the final step
    always_comb begin
        fin_hi_s = acc_step_s[2*WIDTH-1:WIDTH];
        fin_lo_s = acc_step_s[WIDTH-1:0];
        if (op_r[1]) begin
            // Quotient takes s1^s2, remainder takes the dividend sign
            if (sign_1_r ^ sign_2_r) begin
                fin_lo_s = neg_w(acc_step_s[WIDTH-1:0]);
            end else begin
                fin_lo_s = acc_step_s[WIDTH-1:0];
            end
            if (sign_1_r) begin
                fin_hi_s = neg_w(acc_step_s[2*WIDTH-1:WIDTH]);
            end else begin
                fin_hi_s = acc_step_s[2*WIDTH-1:WIDTH];
            end
        end else begin
            if (sign_1_r ^ sign_2_r) begin
                {fin_hi_s, fin_lo_s} = neg_2w(acc_step_s);
            end else begin
                {fin_hi_s, fin_lo_s} = acc_step_s;
            end
        end
    end

    // Next-state logic for IDLE -> CALC -> FINISH -> IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (div_by_zero_s) begin
                        state_next_s = ST_FINISH;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_next_s = ST_IDLE;
                end else if (last_step_s) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_FINISH: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operation context, accumulator, counter and pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 2'b00;
            sign_1_r <= 1'b0;
            sign_2_r <= 1'b0;
            mag_2_r  <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            res_hi_r <= {WIDTH{1'b0}};
            res_lo_r <= {WIDTH{1'b0}};
            dz_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r     <= op;
                        sign_1_r <= in_sign_1_s;
                        sign_2_r <= in_sign_2_s;
                        mag_2_r  <= in_mag_2_s;
                        acc_r    <= {{WIDTH{1'b0}}, in_mag_1_s};
                        cnt_r    <= {CNT_W{1'b0}};
                        // Divide-by-zero skips CALC, so its result is staged right here
                        res_hi_r <= operand_1;
                        res_lo_r <= {WIDTH{1'b1}};
                        dz_r     <= div_by_zero_s;
                    end
                end
                ST_CALC: begin
                    if (!cancel) begin
                        acc_r <= acc_step_s;
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (last_step_s) begin
                            res_hi_r <= fin_hi_s;
                            res_lo_r <= fin_lo_s;
                            dz_r     <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Committed HI/LO: updated only by a FINISH that was not flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if ((state_r == ST_FINISH) && !cancel) begin
            hi_r <= res_hi_r;
            lo_r <= res_lo_r;
        end
    end

    // Handshake and result port; FINISH presents the staged result for its single cycle
    assign busy          = (state_r == ST_CALC) || (state_r == ST_FINISH);
    assign stall_req     = accept_s || (state_r == ST_CALC);
    assign done          = (state_r == ST_FINISH) && !cancel;
    assign hilo_write_en = done;
    assign div_zero      = done && dz_r;
    assign hi_out        = done ? res_hi_r : hi_r;
    assign lo_out        = done ? res_lo_r : lo_r;

endmodule

// File: tb/tb_ex_mul_div.sv
// tb_ex_mul_div: scoreboard bench for ex_mul_div (WIDTH = 32).
// Expected results come from a behavioural 64-bit model pushed at issue time.
module tb_ex_mul_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_1;
    logic [W-1:0] operand_2;
    logic         cancel;
    logic         busy;
    logic         stall_req;
    logic         done;
    logic         hilo_write_en;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         div_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] last_hi = 32'd0;
    logic [W-1:0] last_lo = 32'd0;

    ex_mul_div #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op            (op),
        .operand_1     (operand_1),
        .operand_2     (operand_2),
        .cancel        (cancel),
        .busy          (busy),
        .stall_req     (stall_req),
        .done          (done),
        .hilo_write_en (hilo_write_en),
        .hi_out        (hi_out),
        .lo_out        (lo_out),
        .div_zero      (div_zero)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Hard time bound in case the stimulus itself gets stuck
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: returns {div_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = 65'd0;
        case (o)
            2'b00: begin
                p     = sa * sb;
                model = {1'b0, p[63:0]};
            end
            2'b01: begin
                u     = {32'd0, a} * {32'd0, b};
                model = {1'b0, u};
            end
            default: begin
                if (b == 32'd0) begin
                    model = {1'b1, a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q     = sa / sb;
                    r     = sa % sb;
                    model = {1'b0, r[31:0], q[31:0]};
                end else begin
                    model = {1'b0, a % b, a / b};
                end
            end
        endcase
    endfunction

    // Watch a number of cycles and count any done pulses
    task automatic expect_no_done(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (done) seen++;
            tick();
        end
        check_eq(tag, 64'(seen), 64'd0);
    endtask

    // Issue one op, optionally poke start while busy, wait for done and score it
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke);
        exp_t        e;
        exp_t        g;
        logic [64:0] m;
        int          cyc;
        int          stall_n;
        m     = model(o, a, b);
        e.dz  = m[64];
        e.hi  = m[63:32];
        e.lo  = m[31:0];
        e.lat = (o[1] && (b == 32'd0)) ? 1 : W + 1;
        sb_q.push_back(e);
        op        = o;
        operand_1 = a;
        operand_2 = b;
        start     = 1'b1;
        #1;
        stall_n = stall_req ? 1 : 0;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 200) begin
            if (stall_req) stall_n++;
            if (cyc == poke) begin
                start     = 1'b1;
                op        = ~o;
                operand_1 = 32'h0000_0009;
                operand_2 = 32'h0000_0000;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        g = sb_q.pop_front();
        if (!done) begin
            check_eq({tag, ".timeout"}, 64'(cyc), 64'(g.lat));
        end else begin
            check_eq({tag, ".latency"}, 64'(cyc), 64'(g.lat));
            check_eq({tag, ".hi"}, 64'(hi_out), 64'(g.hi));
            check_eq({tag, ".lo"}, 64'(lo_out), 64'(g.lo));
            check_eq({tag, ".div_zero"}, 64'(div_zero), 64'(g.dz));
            check_eq({tag, ".wr_en"}, 64'(hilo_write_en), 64'd1);
            check_eq({tag, ".stall_cycles"}, 64'(stall_n), 64'(g.lat));
            check_eq({tag, ".stall_at_done"}, 64'(stall_req), 64'd0);
            last_hi = g.hi;
            last_lo = g.lo;
            tick();
            check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
            check_eq({tag, ".idle_after"}, 64'(busy), 64'd0);
            check_eq({tag, ".hold"}, {32'(hi_out), 32'(lo_out)}, {last_hi, last_lo});
        end
    endtask

    // Main stimulus sequence
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cancel    = 1'b0;
        op        = 2'b00;
        operand_1 = 32'd0;
        operand_2 = 32'd0;
        tick();
        tick();
        check_eq("reset.outs", {58'd0, busy, stall_req, done, hilo_write_en, div_zero, 1'b0},
                 64'd0);
        check_eq("reset.hilo", {32'(hi_out), 32'(lo_out)}, 64'd0);
        rst = 1'b0;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, -1);
        run_op("mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("divu_7d2", 2'b11, 32'd7, 32'd2, -1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0, -1);
        run_op("div_zero_s", 2'b10, 32'hFFFF_FF00, 32'd0, -1);
        run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, -1);
        run_op("div_poke5", 2'b10, 32'd1000, 32'hFFFF_FFF9, 5);

        for (int i = 0; i < 8; i++) begin
            run_op("random", 2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom), -1);
        end

        // Flush of a MULT at cycle 10
        op        = 2'b00;
        operand_1 = 32'd5;
        operand_2 = 32'd6;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_eq("cancel_calc.busy", 64'(busy), 64'd0);
        check_eq("cancel_calc.stall", 64'(stall_req), 64'd0);
        expect_no_done("cancel_calc.no_done", 40);
        check_eq("cancel_calc.hilo", {32'(hi_out), 32'(lo_out)}, {last_hi, last_lo});

        // Flush arriving in FINISH suppresses done and the HI/LO write
        op        = 2'b01;
        operand_1 = 32'd11;
        operand_2 = 32'd13;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < W + 1; c++) tick();
        cancel = 1'b1;
        #1;
        check_eq("cancel_fin.busy", 64'(busy), 64'd1);
        check_eq("cancel_fin.done", 64'(done), 64'd0);
        check_eq("cancel_fin.wr_en", 64'(hilo_write_en), 64'd0);
        check_eq("cancel_fin.hilo_now", {32'(hi_out), 32'(lo_out)}, {last_hi, last_lo});
        tick();
        cancel = 1'b0;
        check_eq("cancel_fin.idle", 64'(busy), 64'd0);
        expect_no_done("cancel_fin.no_done", 5);
        check_eq("cancel_fin.hilo", {32'(hi_out), 32'(lo_out)}, {last_hi, last_lo});

        // start and cancel together in IDLE: cancel wins
        op        = 2'b11;
        operand_1 = 32'd50;
        operand_2 = 32'd0;
        start     = 1'b1;
        cancel    = 1'b1;
        #1;
        check_eq("start_cancel.stall", 64'(stall_req), 64'd0);
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check_eq("start_cancel.busy", 64'(busy), 64'd0);
        expect_no_done("start_cancel.no_done", 5);

        // Reset in the middle of a divide
        op        = 2'b11;
        operand_1 = 32'd100;
        operand_2 = 32'd7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid.outs", {58'd0, busy, stall_req, done, hilo_write_en, div_zero, 1'b0},
                 64'd0);
        check_eq("rst_mid.hilo", {32'(hi_out), 32'(lo_out)}, 64'd0);
        expect_no_done("rst_mid.no_done", 40);
        last_hi = 32'd0;
        last_lo = 32'd0;

        // A fresh op after reset still works
        run_op("after_rst", 2'b00, 32'h0001_0000, 32'h0001_0000, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
